mult_seq: RTL and testbench

//  Sequencer/arbiter for the shared iterative 32x32 signed multiplier (1 load cycle + N_ITER shift-add cycles).

---
 rtl/mult_seq_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 46 ++++
 rtl/mult_seq.sv | 174 +++++++++++++++++
 tb/tb_mult_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg
// Shared definitions for the multiplier sequencer slice: default operand
// width and iteration count, number of requesting ports, and the
// sequencer state encoding.
package mult_seq_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int N_ITER_DEF = 32;
  localparam int NREQ       = 2;

  // IDLE: waiting for a request; LOAD: multiplier load strobe;
  // RUN: shift-add iterations; CAPT: product captured into HI/LO.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    CAPT = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. A lone request always wins; when both ports
// request, the port that was not granted last time wins. The remembered
// "last granted" port only moves when the caller accepts a grant.
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset (last granted = port 1, so
//              port 0 wins the first tie)
//   i_req      per-port request levels
//   i_advance  caller accepts the current grant this cycle
//   o_grant    one-hot combinational grant (zero when nobody requests)
module rr_arb2
  import mult_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant
);

  logic r_lastPort;

  // Pick the winner from the current request pattern. Only the tie case
  // looks at which port was served last, so that port yields.
  always_comb begin
    o_grant = '0;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_lastPort ? 2'b01 : 2'b10;
      default: o_grant = '0;
    endcase
  end

  // Remember who was served, but only once the grant is actually taken,
  // so an unaccepted winner does not lose its turn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lastPort <= 1'b1;
    end else if (i_advance && (|i_req)) begin
      r_lastPort <= o_grant[1];
    end
  end

endmodule

// File: rtl/mult_seq.sv
// mult_seq
// Sequencer for a shared iterative signed multiplier (one load cycle followed
// by N_ITER shift-add cycles). Arbitrates two requesters round-robin, latches
// the winner's operands, strobes the multiplier load, counts iterations, then
// captures the 64-bit product into the architectural HI/LO registers and
// pulses done for the port that owned the operation.
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   req[1:0]            request levels (port 0 = main unit, port 1 = aux unit)
//   a0,b0 / a1,b1       per-port signed operands
//   grant[1:0]          registered one-hot owner of the current operation
//   busy                high from LOAD through CAPT
//   done[1:0]           one-cycle pulse, HI/LO valid for that port
//   mul_srcA/mul_srcB   latched operands to the multiplier
//   mul_ctrl            multiplier load strobe (1 = load, 0 = iterate)
//   mul_hi/mul_lo       product halves from the multiplier
//   hi, lo              architectural HI/LO registers
// Optional build macro MULT_HILO_WRITE_EN adds hilo_we[1:0] ({HI,LO} write
// enables) and hilo_wdata, giving direct HI/LO writes while idle.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int N_ITER = N_ITER_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [NREQ-1:0]  grant,
  output logic             busy,
  output logic [NREQ-1:0]  done,
  output logic [WIDTH-1:0] mul_srcA,
  output logic [WIDTH-1:0] mul_srcB,
  output logic             mul_ctrl,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic [WIDTH-1:0] mul_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULT_HILO_WRITE_EN
  ,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata
`endif
);

  localparam int CNT_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [NREQ-1:0]  r_grant;
  logic [NREQ-1:0]  r_done;
  logic [WIDTH-1:0] r_srcA;
  logic [WIDTH-1:0] r_srcB;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [NREQ-1:0]  w_arbGrant;
  logic             w_advance;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req     (req),
    .i_advance (w_advance),
    .o_grant   (w_arbGrant)
  );

  // Next-state and control decode. A grant is accepted only from IDLE; the
  // load strobe is asserted for the single LOAD cycle, and RUN lasts until
  // the counter has seen N_ITER cycles.
  always_comb begin
    w_next    = r_state;
    w_advance = 1'b0;
    mul_ctrl  = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (|req) begin
          w_advance = 1'b1;
          w_next    = LOAD;
        end
      end
      LOAD: begin
        mul_ctrl = 1'b1;
        w_next   = RUN;
      end
      RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_next = CAPT;
        end
      end
      CAPT: begin
        w_next = IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  // State register. Reset mid-operation simply abandons the operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath: operand latches, iteration counter, HI/LO and the done pulse.
  // Operands are captured once at grant time so requesters may change them
  // freely afterwards. done is cleared every cycle unless CAPT sets it, which
  // makes it a single-cycle pulse aligned with the new HI/LO values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_srcA  <= '0;
      r_srcB  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_advance) begin
            r_grant <= w_arbGrant;
            r_srcA  <= w_arbGrant[1] ? a1 : a0;
            r_srcB  <= w_arbGrant[1] ? b1 : b0;
          end
`ifdef MULT_HILO_WRITE_EN
          if (hilo_we[1]) begin
            r_hi <= hilo_wdata;
          end
          if (hilo_we[0]) begin
            r_lo <= hilo_wdata;
          end
`endif
        end
        LOAD: begin
          r_cnt <= '0;
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        CAPT: begin
          r_hi    <= mul_hi;
          r_lo    <= mul_lo;
          r_done  <= r_grant;
          r_grant <= '0;
        end
        default: begin
          r_grant <= '0;
        end
      endcase
    end
  end

  assign grant    = r_grant;
  assign done     = r_done;
  assign mul_srcA = r_srcA;
  assign mul_srcB = r_srcB;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq
// Self-checking bench for mult_seq. A behavioural iterative multiplier drives
// mul_hi/mul_lo and only presents the true product after exactly 32 iterate
// cycles following a load (garbage otherwise). Expected results go into a
// scoreboard queue when requests are driven and are popped when done pulses.
// Build with MULT_HILO_WRITE_EN to also exercise the direct HI/LO write port.
module tb_mult_seq;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] a0, b0, a1, b1;
  logic [1:0]  grant;
  logic        busy;
  logic [1:0]  done;
  logic [31:0] mul_srcA, mul_srcB;
  logic        mul_ctrl;
  logic [31:0] mul_hi, mul_lo;
  logic [31:0] hi, lo;
`ifdef MULT_HILO_WRITE_EN
  logic [1:0]  hilo_we;
  logic [31:0] hilo_wdata;
`endif

  typedef struct {
    int          port;
    logic [63:0] prod;
  } exp_t;

  exp_t sbq[$];
  int   nCmp;
  int   nErr;
  int   lastPort;

  mult_seq dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .a0       (a0),
    .b0       (b0),
    .a1       (a1),
    .b1       (b1),
    .grant    (grant),
    .busy     (busy),
    .done     (done),
    .mul_srcA (mul_srcA),
    .mul_srcB (mul_srcB),
    .mul_ctrl (mul_ctrl),
    .mul_hi   (mul_hi),
    .mul_lo   (mul_lo),
    .hi       (hi),
    .lo       (lo)
`ifdef MULT_HILO_WRITE_EN
    ,
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural iterative multiplier: loads on the strobe, then needs 32
  // iterate cycles before its output is the signed product.
  logic signed [31:0] mdlA, mdlB;
  logic signed [63:0] mdlExtA, mdlExtB, mdlProd;
  int                 mdlIt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdlA  <= '0;
      mdlB  <= '0;
      mdlIt <= 0;
    end else if (mul_ctrl) begin
      mdlA  <= mul_srcA;
      mdlB  <= mul_srcB;
      mdlIt <= 0;
    end else if (mdlIt < 32) begin
      mdlIt <= mdlIt + 1;
    end
  end

  assign mdlExtA = mdlA;
  assign mdlExtB = mdlB;
  assign mdlProd = mdlExtA * mdlExtB;
  assign {mul_hi, mul_lo} = (mdlIt == 32) ? mdlProd : 64'hBAD0_0BAD_DEAD_BEEF;

  function automatic logic [63:0] sprod(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] ex, ey;
    ex = $signed(x);
    ey = $signed(y);
    return ex * ey;
  endfunction

  // Waits for a done pulse (bounded), observing the operation without judging
  // it. Cycle 1 is the negedge after the request was presented.
  task automatic applyStimulus(input int dropAt, input bit dropOnDone, input bit scramble,
                               output int cyc, output logic [1:0] d, output logic [63:0] hl,
                               output int ctrlHighs, output logic [1:0] g1, output logic bsy1);
    cyc = -1; d = '0; hl = '0; ctrlHighs = 0; g1 = '0; bsy1 = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        g1   = grant;
        bsy1 = busy;
        if (scramble) begin
          a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        end
      end
      if (mul_ctrl) ctrlHighs++;
      if (c == dropAt) req = '0;
      if (done != 2'b00) begin
        cyc = c;
        d   = done;
        hl  = {hi, lo};
        if (dropOnDone) req = '0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    lastPort = 1;
    repeat (2) @(negedge clk);
    nCmp++; if (grant !== 2'b00) begin nErr++; $display("[TB] FAIL reset_grant: got %b expected 00", grant); end
    nCmp++; if (busy !== 1'b0) begin nErr++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    nCmp++; if (done !== 2'b00) begin nErr++; $display("[TB] FAIL reset_done: got %b expected 00", done); end
    nCmp++; if (mul_ctrl !== 1'b0) begin nErr++; $display("[TB] FAIL reset_mulctrl: got %b expected 0", mul_ctrl); end
    nCmp++; if ({mul_srcA, mul_srcB} !== 64'd0) begin nErr++; $display("[TB] FAIL reset_src: got %h expected 0", {mul_srcA, mul_srcB}); end
    nCmp++; if ({hi, lo} !== 64'd0) begin nErr++; $display("[TB] FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    reset = 1'b0;
    @(negedge clk);
    nCmp++; if (busy !== 1'b0) begin nErr++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int cyc, ch; logic [1:0] d, g1; logic [63:0] hl; logic bs; exp_t e;
    a0 = 32'd7; b0 = 32'd6; a1 = 32'hFFFF_FFFD; b1 = 32'd5;
    for (int k = 0; k < 4; k++) begin
      sbq.push_back('{port: k % 2, prod: (k % 2) ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'd42});
    end
    lastPort = 1;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(-1, (k == 3), 1'b0, cyc, d, hl, ch, g1, bs);
      if (sbq.size() == 0) begin
        nCmp++; nErr++; $display("[TB] FAIL b2b_sb_empty: got done %b expected none", d);
      end else begin
        e = sbq.pop_front();
        nCmp++; if (g1 !== (2'b01 << e.port)) begin nErr++; $display("[TB] FAIL b2b_grant%0d: got %b expected %b", k, g1, 2'b01 << e.port); end
        nCmp++; if (cyc !== 35) begin nErr++; $display("[TB] FAIL b2b_latency%0d: got %0d expected 35", k, cyc); end
        nCmp++; if (d !== (2'b01 << e.port)) begin nErr++; $display("[TB] FAIL b2b_done%0d: got %b expected %b", k, d, 2'b01 << e.port); end
        nCmp++; if (hl !== e.prod) begin nErr++; $display("[TB] FAIL b2b_hilo%0d: got %h expected %h", k, hl, e.prod); end
        nCmp++; if (ch !== 1) begin nErr++; $display("[TB] FAIL b2b_mulctrl%0d: got %0d strobes expected 1", k, ch); end
        nCmp++; if (bs !== 1'b1) begin nErr++; $display("[TB] FAIL b2b_busy%0d: got %b expected 1", k, bs); end
        lastPort = e.port;
      end
    end
    @(negedge clk);
    nCmp++; if (done !== 2'b00) begin nErr++; $display("[TB] FAIL b2b_pulse: got %b expected 00", done); end
    nCmp++; if (busy !== 1'b0) begin nErr++; $display("[TB] FAIL b2b_idle: got %b expected 0", busy); end
  endtask

  task automatic test_single_minint();
    int cyc, ch; logic [1:0] d, g1; logic [63:0] hl; logic bs; exp_t e;
    a0 = 32'h8000_0000; b0 = 32'h8000_0000;
    sbq.push_back('{port: 0, prod: 64'h4000_0000_0000_0000});
    lastPort = 0;
    req = 2'b01;
    applyStimulus(-1, 1'b1, 1'b1, cyc, d, hl, ch, g1, bs);
    e = sbq.pop_front();
    nCmp++; if (cyc !== 35) begin nErr++; $display("[TB] FAIL min_latency: got %0d expected 35", cyc); end
    nCmp++; if (d !== 2'b01) begin nErr++; $display("[TB] FAIL min_done: got %b expected 01", d); end
    nCmp++; if (hl !== e.prod) begin nErr++; $display("[TB] FAIL min_hilo: got %h expected %h", hl, e.prod); end
    nCmp++; if (g1 !== 2'b01) begin nErr++; $display("[TB] FAIL min_grant: got %b expected 01", g1); end
    @(negedge clk);
    nCmp++; if (grant !== 2'b00) begin nErr++; $display("[TB] FAIL min_grant_clear: got %b expected 00", grant); end
  endtask

  task automatic test_drop_req();
    int cyc, ch; logic [1:0] d, g1; logic [63:0] hl; logic bs; exp_t e;
    a1 = 32'hFFFF_FFFD; b1 = 32'd5;
    sbq.push_back('{port: 1, prod: 64'hFFFF_FFFF_FFFF_FFF1});
    lastPort = 1;
    req = 2'b10;
    applyStimulus(5, 1'b1, 1'b0, cyc, d, hl, ch, g1, bs);
    e = sbq.pop_front();
    nCmp++; if (cyc !== 35) begin nErr++; $display("[TB] FAIL drop_latency: got %0d expected 35", cyc); end
    nCmp++; if (d !== 2'b10) begin nErr++; $display("[TB] FAIL drop_done: got %b expected 10", d); end
    nCmp++; if (hl !== e.prod) begin nErr++; $display("[TB] FAIL drop_hilo: got %h expected %h", hl, e.prod); end
  endtask

  task automatic test_random();
    int cyc, ch, port; logic [1:0] d, g1, pat; logic [63:0] hl; logic bs; exp_t e;
    for (int k = 0; k < 6; k++) begin
      pat = 2'($urandom_range(1, 3));
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      if (pat == 2'b01) port = 0;
      else if (pat == 2'b10) port = 1;
      else port = (lastPort == 0) ? 1 : 0;
      sbq.push_back('{port: port, prod: (port == 1) ? sprod(a1, b1) : sprod(a0, b0)});
      lastPort = port;
      req = pat;
      applyStimulus(-1, 1'b1, 1'b1, cyc, d, hl, ch, g1, bs);
      e = sbq.pop_front();
      nCmp++; if (g1 !== (2'b01 << e.port)) begin nErr++; $display("[TB] FAIL rnd_grant%0d: got %b expected %b (req %b)", k, g1, 2'b01 << e.port, pat); end
      nCmp++; if (cyc !== 35) begin nErr++; $display("[TB] FAIL rnd_latency%0d: got %0d expected 35", k, cyc); end
      nCmp++; if (hl !== e.prod) begin nErr++; $display("[TB] FAIL rnd_hilo%0d: got %h expected %h", k, hl, e.prod); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, ch, seen; logic [1:0] d, g1; logic [63:0] hl; logic bs; exp_t e;
    a0 = 32'd11; b0 = 32'd13;
    req = 2'b01;
    repeat (12) @(negedge clk);
    nCmp++; if (busy !== 1'b1) begin nErr++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    #1;
    nCmp++; if (grant !== 2'b00) begin nErr++; $display("[TB] FAIL mid_grant: got %b expected 00", grant); end
    nCmp++; if (busy !== 1'b0) begin nErr++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    nCmp++; if ({hi, lo} !== 64'd0) begin nErr++; $display("[TB] FAIL mid_hilo: got %h expected 0", {hi, lo}); end
    req = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done != 2'b00) seen++;
    end
    nCmp++; if (seen !== 0) begin nErr++; $display("[TB] FAIL mid_nodone: got %0d pulses expected 0", seen); end
    a0 = 32'd100; b0 = 32'hFFFF_FFFE;
    sbq.push_back('{port: 0, prod: 64'hFFFF_FFFF_FFFF_FF38});
    lastPort = 0;
    req = 2'b01;
    applyStimulus(-1, 1'b1, 1'b0, cyc, d, hl, ch, g1, bs);
    e = sbq.pop_front();
    nCmp++; if (cyc !== 35) begin nErr++; $display("[TB] FAIL mid_fresh_latency: got %0d expected 35", cyc); end
    nCmp++; if (d !== 2'b01) begin nErr++; $display("[TB] FAIL mid_fresh_done: got %b expected 01", d); end
    nCmp++; if (hl !== e.prod) begin nErr++; $display("[TB] FAIL mid_fresh_hilo: got %h expected %h", hl, e.prod); end
  endtask

`ifdef MULT_HILO_WRITE_EN
  task automatic test_hilo_write();
    int cyc, ch; logic [1:0] d, g1; logic [63:0] hl; logic bs; logic [31:0] prevLo; exp_t e;
    prevLo = lo;
    hilo_we = 2'b10; hilo_wdata = 32'h1234;
    @(negedge clk);
    hilo_we = 2'b00;
    nCmp++; if (hi !== 32'h1234) begin nErr++; $display("[TB] FAIL wr_hi: got %h expected 00001234", hi); end
    nCmp++; if (lo !== prevLo) begin nErr++; $display("[TB] FAIL wr_lo_keep: got %h expected %h", lo, prevLo); end
    hilo_we = 2'b11; hilo_wdata = 32'hA5A5;
    @(negedge clk);
    hilo_we = 2'b00;
    nCmp++; if ({hi, lo} !== 64'h0000_A5A5_0000_A5A5) begin nErr++; $display("[TB] FAIL wr_both: got %h expected 0000a5a50000a5a5", {hi, lo}); end
    a0 = 32'd2; b0 = 32'd3;
    sbq.push_back('{port: 0, prod: 64'd6});
    lastPort = 0;
    req = 2'b01;
    repeat (5) @(negedge clk);
    hilo_we = 2'b10; hilo_wdata = 32'h9999;
    @(negedge clk);
    hilo_we = 2'b00;
    nCmp++; if (hi !== 32'hA5A5) begin nErr++; $display("[TB] FAIL wr_busy_ignored: got %h expected 0000a5a5", hi); end
    applyStimulus(-1, 1'b1, 1'b0, cyc, d, hl, ch, g1, bs);
    e = sbq.pop_front();
    nCmp++; if (cyc !== 29) begin nErr++; $display("[TB] FAIL wr_latency: got %0d expected 29", cyc); end
    nCmp++; if (hl !== e.prod) begin nErr++; $display("[TB] FAIL wr_product: got %h expected %h", hl, e.prod); end
  endtask
`endif

  // Guards against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nCmp = 0;
    nErr = 0;
`ifdef MULT_HILO_WRITE_EN
    hilo_we = 2'b00;
    hilo_wdata = '0;
`endif
    test_reset();
    test_back_to_back();
    test_single_minint();
    test_drop_req();
    test_random();
    test_reset_mid();
`ifdef MULT_HILO_WRITE_EN
    test_hilo_write();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
